// File: rtl/ti_sbox_pkg.sv
// Shared constants, FSM state type and share-nibble packing helpers for the
// serial threshold-implementation S-box controller.
package ti_sbox_pkg;

    localparam int NIB_W  = 4;
    localparam int NSHARE = 2;
    localparam int PACK_W = NIB_W * NSHARE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Packing order on the S-box bank interface: {share1 nibble, share0 nibble}.
    function automatic logic [PACK_W-1:0] pack_nib(input logic [NIB_W-1:0] s0,
                                                   input logic [NIB_W-1:0] s1);
        return {s1, s0};
    endfunction

    function automatic logic [NIB_W-1:0] nib_sh0(input logic [PACK_W-1:0] x);
        return x[NIB_W-1:0];
    endfunction

    function automatic logic [NIB_W-1:0] nib_sh1(input logic [PACK_W-1:0] x);
        return x[PACK_W-1:NIB_W];
    endfunction

endpackage

// File: rtl/ti_share_shreg.sv
// One share of the masked state: parallel load, right shift by one nibble with
// a new top nibble, and a tap on the lowest nibble. Holds when idle.
module ti_share_shreg
    import ti_sbox_pkg::*;
#(
    parameter int NIB = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NIB*NIB_W-1:0] load_val,
    input  logic                 shift,
    input  logic [NIB_W-1:0]     shift_in,
    output logic [NIB*NIB_W-1:0] q,
    output logic [NIB_W-1:0]     tap
);

    localparam int W = NIB * NIB_W;

    // Load takes priority; otherwise shift right, inserting the new top nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {shift_in, q[W-1:NIB_W]};
        end
    end

    assign tap = q[NIB_W-1:0];

endmodule

// File: rtl/ti_sbox_serial_ctrl.sv
// Serial controller for a shared two-stage TI S-box: streams the 2-share
// state one nibble per cycle through the external stage-1 and stage-2 banks,
// with the mandatory register between them, and handles both handshakes.
// Share 0 and share 1 paths never meet inside this block.
module ti_sbox_serial_ctrl
    import ti_sbox_pkg::*;
#(
    parameter int NIB   = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIB*NIB_W-1:0] in_sh0,
    input  logic [NIB*NIB_W-1:0] in_sh1,
    output logic [PACK_W-1:0]    st1_x,
    input  logic [PACK_W-1:0]    st1_y,
    output logic [PACK_W-1:0]    st2_x,
    input  logic [PACK_W-1:0]    st2_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NIB*NIB_W-1:0] out_sh0,
    output logic [NIB*NIB_W-1:0] out_sh1,
    output logic                 busy
);

    // The drain cycle: NIB+1 shifts in total so the first (garbage) nibble
    // pushed in at the top falls out of the bottom.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PACK_W-1:0]  stage;
    logic [NIB_W-1:0]   tap0;
    logic [NIB_W-1:0]   tap1;
    logic               load;
    logic               shift;

    assign load  = (state == IDLE) && in_valid && in_ready;
    assign shift = (state == RUN);

    // Control FSM with nibble counter; all handshake/status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= RUN;
                        count    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Inter-stage register between the two S-box stages; frozen outside RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else if (shift) begin
            stage <= st1_y;
        end
    end

    ti_share_shreg #(.NIB(NIB)) u_sh0 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (in_sh0),
        .shift    (shift),
        .shift_in (nib_sh0(st2_y)),
        .q        (out_sh0),
        .tap      (tap0)
    );

    ti_share_shreg #(.NIB(NIB)) u_sh1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (in_sh1),
        .shift    (shift),
        .shift_in (nib_sh1(st2_y)),
        .q        (out_sh1),
        .tap      (tap1)
    );

    assign st1_x = pack_nib(tap0, tap1);
    assign st2_x = stage;

endmodule

// File: tb/tb_ti_sbox_serial_ctrl.sv
// Self-checking bench for ti_sbox_serial_ctrl with stub S-box stage banks
// and a nibble-wise reference model of the composed substitution.
module tb_ti_sbox_serial_ctrl;

    localparam int NIB = 16;
    localparam int LAT = NIB + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sh0;
    logic [63:0] in_sh1;
    logic [7:0]  st1_x;
    logic [7:0]  st1_y;
    logic [7:0]  st2_x;
    logic [7:0]  st2_y;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sh0;
    logic [63:0] out_sh1;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int mode     = 0;
    int cyc      = 0;
    int cyc_acc  = 0;

    logic [3:0] present_tbl [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    ti_sbox_serial_ctrl #(.NIB(NIB), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sh0    (in_sh0),
        .in_sh1    (in_sh1),
        .st1_x     (st1_x),
        .st1_y     (st1_y),
        .st2_x     (st2_x),
        .st2_y     (st2_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sh0   (out_sh0),
        .out_sh1   (out_sh1),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stage-1 stub function on one share nibble.
    function automatic logic [3:0] s1f(input logic [3:0] n, input int m);
        case (m)
            0:       return n;
            1:       return n + 4'h1;
            default: return n ^ 4'hA;
        endcase
    endfunction

    // Stage-2 stub function on one share nibble.
    function automatic logic [3:0] s2f(input logic [3:0] n, input int m);
        case (m)
            0:       return ~n;
            1:       return n;
            default: return present_tbl[n];
        endcase
    endfunction

    always_comb begin
        st1_y = {s1f(st1_x[7:4], mode), s1f(st1_x[3:0], mode)};
        st2_y = {s2f(st2_x[7:4], mode), s2f(st2_x[3:0], mode)};
    end

    // Expected result of one share: every nibble goes through stage 1 then stage 2.
    function automatic logic [63:0] ref_share(input logic [63:0] x, input int m);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NIB; i++) r[4*i +: 4] = s2f(s1f(x[4*i +: 4], m), m);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Called just after a negedge. Presents a state and waits for its acceptance;
    // optionally pulses in_valid with junk during RUN, which must be ignored.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input int bp,
                            input bit pulse);
        bit ok;
        ok = 0;
        in_valid  = 1'b1;
        in_sh0    = a;
        in_sh1    = b;
        out_ready = (bp == 0);
        for (int k = 0; k < 50 && !ok; k++) begin
            if (in_ready) ok = 1;
            else @(negedge clk);
        end
        check("accept_timeout", 64'(ok), 64'd1);
        cyc_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_run", 64'(busy), 64'd1);
        check("in_ready_run", 64'(in_ready), 64'd0);
        if (pulse) begin
            repeat ($urandom_range(0, 8)) @(negedge clk);
            in_valid = 1'b1;
            in_sh0   = {$urandom, $urandom};
            in_sh1   = {$urandom, $urandom};
            @(negedge clk);
            in_valid = 1'b0;
            check("busy_pulse", 64'(busy), 64'd1);
        end
    endtask

    // Waits for the result, checks it, applies bp cycles of backpressure and
    // completes the output handshake. With nv set, the next state is presented
    // with in_valid high before the handshake.
    task automatic finish_op(input logic [63:0] e0, input logic [63:0] e1, input int bp,
                             input bit nv, input logic [63:0] na, input logic [63:0] nb);
        bit ok;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (out_valid) ok = 1;
            else @(negedge clk);
        end
        check("done_timeout", 64'(ok), 64'd1);
        check("latency", 64'(cyc - cyc_acc), 64'(LAT));
        check("out_sh0", out_sh0, e0);
        check("out_sh1", out_sh1, e1);
        check("busy_done", 64'(busy), 64'd0);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_sh0", out_sh0, e0);
            check("bp_sh1", out_sh1, e1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        if (nv) begin
            in_valid = 1'b1;
            in_sh0   = na;
            in_sh1   = nb;
        end
        @(negedge clk);
        check("post_hs_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b;
        int bp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sh0    = '0;
        in_sh1    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_sh0", out_sh0, 64'd0);
        check("rst_out_sh1", out_sh1, 64'd0);
        check("rst_st2_x", 64'(st2_x), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Basic, then the same stimulus under backpressure.
        mode = 0;
        start_op(64'h0123456789ABCDEF, 64'h0, 0, 0);
        finish_op(64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF, 0, 0, '0, '0);
        start_op(64'h0123456789ABCDEF, 64'h0, 5, 0);
        finish_op(64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF, 5, 0, '0, '0);

        // Back-to-back: second state waiting with in_valid high.
        start_op(64'h0123456789ABCDEF, 64'h0, 0, 0);
        finish_op(64'hFEDCBA9876543210, 64'hFFFFFFFFFFFFFFFF, 0, 1,
                  64'hFFFF0000FFFF0000, 64'h5555);
        start_op(64'hFFFF0000FFFF0000, 64'h5555, 0, 0);
        finish_op(64'h0000FFFF0000FFFF, 64'hFFFFFFFFFFFFAAAA, 0, 0, '0, '0);

        // Stage ordering: stage 1 adds one, stage 2 passes through.
        mode = 1;
        start_op(64'h0, 64'h0, 0, 0);
        finish_op(64'h1111111111111111, 64'h1111111111111111, 0, 0, '0, '0);

        // Reset while RUN count is 7.
        mode = 0;
        start_op(64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 0, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_sh0", out_sh0, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        start_op(64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 0, 0);
        finish_op(ref_share(64'h0123456789ABCDEF, 0), ref_share(64'hDEADBEEFCAFEF00D, 0),
                  0, 0, '0, '0);

        // Randomized operations, with ignored in_valid pulses during RUN.
        for (int t = 0; t < 10; t++) begin
            mode = (t % 2 == 0) ? 2 : 0;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            bp = $urandom_range(0, 3);
            start_op(a, b, bp, 1);
            finish_op(ref_share(a, mode), ref_share(b, mode), bp, 0, '0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ti_sbox_serial_ctrl.md
Name: ti_sbox_serial_ctrl

Overview:
- Sequences a 64-bit, 2-share state through one shared two-stage threshold-implementation S-box, one nibble per cycle.
- The S-box stage logic sits outside this block: stage-1 and stage-2 coordinate-function banks, each taking an 8-bit shared nibble (2 shares x 4 bits).
- This block owns the state shift register, the mandatory inter-stage register between R1 and R2, the nibble counter and the ready/valid handshakes.
- Sits between the round-key-add datapath and the permutation layer.

Parameters:
- NIB, 16, nibbles per share (state width per share = 4*NIB).
- CNT_W, 5, counter width; must satisfy 2^CNT_W > NIB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input state presented.
- in_ready  out  1  block can accept a state.
- in_sh0  in  4*NIB  share 0 of input state.
- in_sh1  in  4*NIB  share 1 of input state.
- st1_x  out  8  to stage-1 bank: {sh1[3:0], sh0[3:0]} of current nibble.
- st1_y  in  8  stage-1 bank result, same packing.
- st2_x  out  8  inter-stage register contents, drives stage-2 bank.
- st2_y  in  8  stage-2 bank result, same packing.
- out_valid  out  1  substituted state available.
- out_ready  in  1  consumer accepts.
- out_sh0  out  4*NIB  share 0 of result.
- out_sh1  out  4*NIB  share 1 of result.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, count=0, share registers=0, inter-stage register=0. Outputs: in_ready=0 while rst is high, then 1 from the first edge after release; out_valid=0, busy=0, out_sh*=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load both shares into share registers, count=0, go to RUN.
- RUN:
  - busy=1, in_ready=0.
  - st1_x = low nibble of each share register.
  - Every cycle: inter-stage reg <= st1_y.
  - Every cycle: each share register shifts right by 4, and the top nibble takes the corresponding share nibble of st2_y.
  - count increments each cycle.
  - When count==NIB (the drain cycle, the (NIB+1)th shift), go to DONE.
  - Result: after NIB+1 shifts, nibble i of each share holds S(nibble i). The top nibble shifted in on the first RUN cycle is garbage and is shifted out by the end.
- Latency: accept edge to out_valid rising = NIB+2 cycles (1 load + NIB+1 RUN); 18 for the default.
- DONE:
  - out_valid=1; out_sh* = share registers.
  - Registers are held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle turnaround.
- st1_x and st2_x are don't-care outside RUN but must not glitch the share registers; they hold their last values.
- in_valid while not in_ready is ignored; it must be held by the producer.
- Reset mid-RUN or mid-DONE: immediate return to reset state; the partial state is discarded.
- No unmasking: shares are never combined inside this block. Share 0 and share 1 registers are physically separate, with no logic mixing them, which keeps the TI non-completeness property intact.

Decomposition:
- Package ti_sbox_pkg holds:
  - constants NIB_W=4, NSHARE=2;
  - state enum {IDLE, RUN, DONE};
  - helper for 8-bit share-nibble packing order.
- Sub-module ti_share_shreg (one per share, instantiated twice): a 4*NIB shift register with load, shift-in of top nibble, low-nibble tap and hold.
- The FSM/counter lives in the top module.

Test Plan:
All cases use a bench stub: stage-1 = identity (st1_y=st1_x), stage-2 = bitwise NOT (st2_y=~st2_x).
- Basic: in_sh0=64'h0123456789ABCDEF, in_sh1=0, out_ready=1 -> out_valid exactly 18 cycles after accept; out_sh0=64'hFEDCBA9876543210; out_sh1=64'hFFFFFFFFFFFFFFFF.
- Backpressure: same stimulus, out_ready=0 for 5 cycles after out_valid -> outputs stable all 5 cycles; in_ready=0 until the cycle after the handshake.
- Back-to-back: second state 64'hFFFF0000FFFF0000 / 64'h5555 presented with in_valid high continuously -> accepted the cycle after the first output handshake; result ~input per share.
- Stage ordering: stub stage-2 = identity and stage-1 = +1 mod 16 per share nibble; input all-zero -> every output nibble = 4'h1. Any off-by-one in tap/shift appears as a rotated pattern.
- Reset mid-RUN: assert rst at RUN count=7 -> out_valid=0, busy=0, in_ready rises after release; the next operation gives the correct result.
- Ignored input: in_valid pulsed during RUN -> no effect on result or count.
